// File: rtl/hwpe_stream_package.sv
// Shared HWPE stream types: address-generator job descriptor, source/sink control and flags,
// and the sink sequencer state encoding.
package hwpe_stream_package;

  typedef struct packed {
    logic [31:0] base_addr;
    logic [31:0] trans_size;
    logic [15:0] line_stride;
    logic [15:0] line_length;
    logic [15:0] feat_stride;
    logic [15:0] feat_length;
    logic [15:0] feat_roll;
    logic        loop_outer;
    logic        realign_type;
    logic [7:0]  step;
  } ctrl_addressgen_t;

  typedef struct packed {
    logic             req_start;
    ctrl_addressgen_t addressgen_ctrl;
  } ctrl_sourcesink_t;

  typedef struct packed {
    logic ready_start;
    logic done;
  } flags_sourcesink_t;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_START = 2'd1,
    SEQ_WAIT  = 2'd2,
    SEQ_DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/hwpe_stream_sink_job_queue.sv
// Power-of-two FIFO of address-generator job descriptors with synchronous flush.
// Push is refused when full even if a pop happens in the same cycle.
module hwpe_stream_sink_job_queue
  import hwpe_stream_package::*;
#(
  parameter int unsigned NB_JOBS = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  ctrl_addressgen_t data_i,
  input  logic             pop_i,
  output ctrl_addressgen_t data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PtrW = $clog2(NB_JOBS);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(NB_JOBS);

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  ctrl_addressgen_t mem_q [NB_JOBS];
  logic             push_en, pop_en;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FullCnt);
  assign push_en = push_i & ~full_o & ~clear_i;
  assign pop_en  = pop_i & ~empty_o & ~clear_i;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      // Pointers wrap naturally because the depth is a power of two.
      if (push_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push_en, pop_en})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the head is only observed while the queue is non-empty.
  always_ff @(posedge clk_i) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni) !(empty_o && full_o));

endmodule

// File: rtl/hwpe_stream_sink_sequencer.sv
// Queues address-generator jobs and launches them one at a time on a stream sink,
// counting completions and pulsing evt_done_o per finished job.
module hwpe_stream_sink_sequencer
  import hwpe_stream_package::*;
#(
  parameter int unsigned NB_JOBS   = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 job_valid_i,
  output logic                 job_ready_o,
  input  ctrl_addressgen_t     job_i,
  output ctrl_sourcesink_t     ctrl_o,
  input  flags_sourcesink_t    flags_i,
  output logic                 busy_o,
  output logic                 evt_done_o,
  output logic [CNT_WIDTH-1:0] jobs_done_o,
  output logic                 queue_empty_o,
  output logic                 queue_full_o
);

  seq_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0] jobs_done_q, jobs_done_d;
  logic                 q_push, q_pop, q_empty, q_full;
  ctrl_addressgen_t     q_head;

  assign q_push      = job_valid_i & ~q_full;
  assign job_ready_o = ~q_full;

  hwpe_stream_sink_job_queue #(
    .NB_JOBS (NB_JOBS)
  ) i_job_queue (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (q_push),
    .data_i  (job_i),
    .pop_i   (q_pop),
    .data_o  (q_head),
    .empty_o (q_empty),
    .full_o  (q_full)
  );

  always_comb begin
    state_d     = state_q;
    jobs_done_d = jobs_done_q;
    q_pop       = 1'b0;
    evt_done_o  = 1'b0;
    unique case (state_q)
      SEQ_IDLE: begin
        if (!q_empty && flags_i.ready_start) state_d = SEQ_START;
      end
      SEQ_START: begin
        state_d = SEQ_WAIT;
      end
      SEQ_WAIT: begin
        if (flags_i.done) state_d = SEQ_DONE;
      end
      SEQ_DONE: begin
        q_pop       = 1'b1;
        evt_done_o  = 1'b1;
        jobs_done_d = jobs_done_q + CNT_WIDTH'(1);
        state_d     = SEQ_IDLE;
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
    // Flush wins over everything, including a completion landing in the same cycle.
    if (clear_i) begin
      state_d     = SEQ_IDLE;
      jobs_done_d = '0;
      q_pop       = 1'b0;
      evt_done_o  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= SEQ_IDLE;
      jobs_done_q <= '0;
    end else begin
      state_q     <= state_d;
      jobs_done_q <= jobs_done_d;
    end
  end

  // The head cannot change between START and DONE since only DONE pops it.
  always_comb begin
    ctrl_o                 = '0;
    ctrl_o.req_start       = (state_q == SEQ_START);
    ctrl_o.addressgen_ctrl = q_empty ? '0 : q_head;
  end

  assign busy_o        = (state_q != SEQ_IDLE);
  assign jobs_done_o   = jobs_done_q;
  assign queue_empty_o = q_empty;
  assign queue_full_o  = q_full;

  assert property (@(posedge clk_i) disable iff (!rst_ni) ctrl_o.req_start |=> !ctrl_o.req_start);
  assert property (@(posedge clk_i) disable iff (!rst_ni) evt_done_o |=> !evt_done_o);

endmodule

// File: tb/tb_hwpe_stream_sink_sequencer.sv
// Self-checking bench for the sink sequencer: scoreboard of accepted jobs, plus a second
// instance with a 2-bit completion counter sharing all inputs to observe wrap-around.
module tb_hwpe_stream_sink_sequencer;
  import hwpe_stream_package::*;

  localparam int NbJobs = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              job_valid = 1'b0;
  ctrl_addressgen_t  job = '0;
  flags_sourcesink_t flags = '0;

  ctrl_sourcesink_t  ctrl, ctrl2;
  logic              job_ready, busy, evt_done, q_empty, q_full;
  logic              job_ready2, busy2, evt_done2, q_empty2, q_full2;
  logic [15:0]       jobs_done;
  logic [1:0]        jobs_done2;

  int checks = 0;
  int failures = 0;
  ctrl_addressgen_t exp_q[$];

  always #5 clk = ~clk;

  hwpe_stream_sink_sequencer #(.NB_JOBS(NbJobs), .CNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .job_valid_i(job_valid),
    .job_ready_o(job_ready), .job_i(job), .ctrl_o(ctrl), .flags_i(flags), .busy_o(busy),
    .evt_done_o(evt_done), .jobs_done_o(jobs_done), .queue_empty_o(q_empty),
    .queue_full_o(q_full)
  );

  hwpe_stream_sink_sequencer #(.NB_JOBS(NbJobs), .CNT_WIDTH(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .job_valid_i(job_valid),
    .job_ready_o(job_ready2), .job_i(job), .ctrl_o(ctrl2), .flags_i(flags), .busy_o(busy2),
    .evt_done_o(evt_done2), .jobs_done_o(jobs_done2), .queue_empty_o(q_empty2),
    .queue_full_o(q_full2)
  );

  // Scoreboard: record every accepted job; drop everything on reset or flush.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) exp_q.delete();
    else if (job_valid && job_ready) exp_q.push_back(job);
  end

  function automatic ctrl_addressgen_t mk(input int i);
    ctrl_addressgen_t j;
    j = '0;
    j.base_addr   = 32'h1000 + 32'(i) * 32'h100;
    j.trans_size  = 32'd16 + 32'(i);
    j.line_stride = 16'(4 * i + 4);
    j.line_length = 16'(i + 1);
    j.step        = 8'd4;
    j.loop_outer  = i[0];
    return j;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (evt_done !== 1'b0) begin failures++; $display("FAIL reset_evt got=%b exp=0", evt_done); end
    checks++; if (jobs_done !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", jobs_done); end
    checks++; if (ctrl !== '0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", ctrl); end
    checks++; if (job_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", job_ready); end
    checks++; if (q_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", q_empty); end
    checks++; if (q_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", q_full); end
    checks++;
    if ({busy2, evt_done2, jobs_done2, ctrl2 != '0, job_ready2, q_empty2, q_full2} !== 9'b000000110) begin
      failures++;
      $display("FAIL reset_dut2 got busy=%b evt=%b cnt=%0d ctrl=%h rdy=%b emp=%b full=%b exp idle",
               busy2, evt_done2, jobs_done2, ctrl2, job_ready2, q_empty2, q_full2);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_job();
    int pulses = 0;
    int unstable = 0;
    ctrl_addressgen_t got;
    flags.ready_start = 1'b1;
    flags.done = 1'b0;
    job = mk(0);
    job_valid = 1'b1;                                  // cycle 0
    step(); job_valid = 1'b0;                          // cycle 1
    checks++; if (ctrl.req_start !== 1'b0) begin failures++; $display("FAIL single_c1_req got=%b exp=0", ctrl.req_start); end
    step();                                            // cycle 2
    checks++; if (ctrl.req_start !== 1'b1) begin failures++; $display("FAIL single_c2_req got=%b exp=1", ctrl.req_start); end
    checks++; if (ctrl.addressgen_ctrl !== mk(0)) begin failures++; $display("FAIL single_head got=%h exp=%h", ctrl.addressgen_ctrl, mk(0)); end
    for (int c = 3; c <= 20; c++) begin
      step();
      if (ctrl.req_start) pulses++;
      if (ctrl.addressgen_ctrl !== mk(0)) unstable++;
    end
    flags.done = 1'b1;                                 // done in cycle 20
    step(); flags.done = 1'b0;                         // cycle 21
    checks++; if (evt_done !== 1'b1) begin failures++; $display("FAIL single_evt got=%b exp=1", evt_done); end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL single_extra_req got=%0d exp=0", pulses); end
    checks++; if (unstable !== 0) begin failures++; $display("FAIL single_stable got=%0d exp=0", unstable); end
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL single_sb got=empty exp=1 entry"); end
    else begin
      got = exp_q.pop_front();
      if (ctrl.addressgen_ctrl !== got) begin
        failures++; $display("FAIL single_done_head got=%h exp=%h", ctrl.addressgen_ctrl, got);
      end
    end
    step();                                            // cycle 22
    checks++; if (evt_done !== 1'b0) begin failures++; $display("FAIL single_evt_len got=%b exp=0", evt_done); end
    checks++; if (jobs_done !== 16'd1) begin failures++; $display("FAIL single_cnt got=%0d exp=1", jobs_done); end
    checks++; if (busy !== 1'b0 || q_empty !== 1'b1) begin failures++; $display("FAIL single_idle got busy=%b empty=%b exp busy=0 empty=1", busy, q_empty); end
    checks++; if (ctrl !== '0) begin failures++; $display("FAIL single_ctrl_zero got=%h exp=0", ctrl); end
  endtask

  task automatic test_spurious_done();
    flags.done = 1'b1;
    step();
    checks++; if (busy !== 1'b0 || evt_done !== 1'b0) begin failures++; $display("FAIL spurious_state got busy=%b evt=%b exp 0 0", busy, evt_done); end
    flags.done = 1'b0;
    step();
    checks++; if (jobs_done !== 16'd1 || evt_done !== 1'b0) begin failures++; $display("FAIL spurious_cnt got cnt=%0d evt=%b exp cnt=1 evt=0", jobs_done, evt_done); end
  endtask

  task automatic test_ready_start_hold();
    int bad = 0;
    ctrl_addressgen_t got;
    flags.ready_start = 1'b0;
    job = mk(1);
    job_valid = 1'b1;
    step(); job_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (ctrl.req_start || busy || q_empty) bad++;
      step();
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL hold_no_start got=%0d bad cycles exp=0", bad); end
    flags.ready_start = 1'b1;
    step();
    checks++; if (ctrl.req_start !== 1'b1) begin failures++; $display("FAIL hold_req got=%b exp=1", ctrl.req_start); end
    checks++; if (ctrl.addressgen_ctrl !== mk(1)) begin failures++; $display("FAIL hold_head got=%h exp=%h", ctrl.addressgen_ctrl, mk(1)); end
    step(); flags.done = 1'b1;
    step(); flags.done = 1'b0;
    checks++;
    if (evt_done !== 1'b1 || exp_q.size() == 0) begin failures++; $display("FAIL hold_evt got=%b exp=1", evt_done); end
    else got = exp_q.pop_front();
    step();
    checks++; if (jobs_done !== 16'd2) begin failures++; $display("FAIL hold_cnt got=%0d exp=2", jobs_done); end
  endtask

  task automatic test_clear();
    int bad = 0;
    flags.ready_start = 1'b1;
    job_valid = 1'b1; job = mk(2);
    step(); job = mk(3);
    step(); job = mk(4);
    checks++; if (ctrl.req_start !== 1'b1) begin failures++; $display("FAIL clear_req got=%b exp=1", ctrl.req_start); end
    step(); job_valid = 1'b0;
    checks++; if (busy !== 1'b1 || exp_q.size() != 3 || q_empty !== 1'b0) begin failures++; $display("FAIL clear_pre got busy=%b sb=%0d empty=%b exp 1 3 0", busy, exp_q.size(), q_empty); end
    // Flush while a completion and a push arrive in the same cycle.
    clear = 1'b1; flags.done = 1'b1; job_valid = 1'b1; job = mk(9);
    step();
    clear = 1'b0; flags.done = 1'b0; job_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clear_idle got=%b exp=0", busy); end
    checks++; if (q_empty !== 1'b1) begin failures++; $display("FAIL clear_empty got=%b exp=1", q_empty); end
    checks++; if (jobs_done !== 16'd0) begin failures++; $display("FAIL clear_cnt got=%0d exp=0", jobs_done); end
    checks++; if (evt_done !== 1'b0) begin failures++; $display("FAIL clear_evt got=%b exp=0", evt_done); end
    for (int i = 0; i < 5; i++) begin
      step();
      if (evt_done || ctrl.req_start || !q_empty || busy) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL clear_after got=%0d bad cycles exp=0", bad); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] wrap_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    int pushed = 0, done_jobs = 0, req_cnt = 0, wait_cnt = -1;
    int first_evt = -1, fifth_acc = -1;
    bit acc, held = 1'b0, chk_cnt = 1'b0;
    ctrl_addressgen_t got;
    flags.ready_start = 1'b1;
    flags.done = 1'b0;
    job_valid = 1'b1; job = mk(10);
    for (int cyc = 0; cyc < 300 && done_jobs < 5; cyc++) begin
      acc = job_valid && job_ready;
      step();
      flags.done = 1'b0;
      if (acc) begin
        if (pushed == 4) fifth_acc = cyc;
        pushed++;
      end
      if (chk_cnt) begin
        chk_cnt = 1'b0;
        checks++; if (jobs_done !== 16'(done_jobs)) begin failures++; $display("FAIL b2b_cnt got=%0d exp=%0d", jobs_done, done_jobs); end
        checks++; if (jobs_done2 !== wrap_seq[done_jobs-1]) begin failures++; $display("FAIL wrap_cnt got=%0d exp=%0d", jobs_done2, wrap_seq[done_jobs-1]); end
      end
      checks++; if (job_ready !== (exp_q.size() < NbJobs)) begin failures++; $display("FAIL b2b_ready got=%b exp=%b", job_ready, exp_q.size() < NbJobs); end
      checks++; if (q_full !== (exp_q.size() == NbJobs) || q_empty !== (exp_q.size() == 0)) begin failures++; $display("FAIL b2b_flags got full=%b empty=%b occupancy=%0d", q_full, q_empty, exp_q.size()); end
      if (pushed == 4 && job_valid && !job_ready) held = 1'b1;
      if (ctrl.req_start) begin
        req_cnt++;
        wait_cnt = 2;
        checks++;
        if (exp_q.size() == 0 || ctrl.addressgen_ctrl !== exp_q[0]) begin failures++; $display("FAIL b2b_start_head got=%h exp=%h", ctrl.addressgen_ctrl, mk(10 + req_cnt - 1)); end
      end else if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          flags.done = 1'b1;
          wait_cnt = -1;
        end
      end
      if (evt_done) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL b2b_sb got=empty exp=entry"); end
        else begin
          got = exp_q.pop_front();
          if (got !== mk(10 + done_jobs) || ctrl.addressgen_ctrl !== got) begin
            failures++; $display("FAIL b2b_order got=%h exp=%h", ctrl.addressgen_ctrl, mk(10 + done_jobs));
          end
        end
        if (first_evt < 0) first_evt = cyc;
        done_jobs++;
        chk_cnt = 1'b1;
      end
      job_valid = (pushed < 5);
      job = mk(10 + pushed);
    end
    job_valid = 1'b0;
    step();
    checks++; if (done_jobs !== 5 || req_cnt !== 5) begin failures++; $display("FAIL b2b_total got done=%0d starts=%0d exp 5 5", done_jobs, req_cnt); end
    checks++; if (jobs_done !== 16'd5) begin failures++; $display("FAIL b2b_final_cnt got=%0d exp=5", jobs_done); end
    checks++; if (jobs_done2 !== wrap_seq[4]) begin failures++; $display("FAIL wrap_final got=%0d exp=%0d", jobs_done2, wrap_seq[4]); end
    checks++; if (held !== 1'b1) begin failures++; $display("FAIL b2b_held got=%b exp=1", held); end
    checks++; if (fifth_acc < first_evt + 2) begin failures++; $display("FAIL b2b_no_bypass got accept=%0d first_done=%0d exp accept>=done+2", fifth_acc, first_evt); end
    checks++; if (busy !== 1'b0 || q_empty !== 1'b1) begin failures++; $display("FAIL b2b_idle got busy=%b empty=%b exp 0 1", busy, q_empty); end
  endtask

  task automatic test_reset_mid_job();
    int bad = 0;
    flags.ready_start = 1'b1;
    job_valid = 1'b1; job = mk(20);
    step(); job = mk(21);
    step(); job_valid = 1'b0;
    checks++; if (ctrl.req_start !== 1'b1) begin failures++; $display("FAIL rstmid_req got=%b exp=1", ctrl.req_start); end
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || evt_done !== 1'b0 || q_empty !== 1'b1 || jobs_done !== 16'd0 || ctrl !== '0 || job_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_state got busy=%b evt=%b empty=%b cnt=%0d ctrl=%h rdy=%b exp idle",
               busy, evt_done, q_empty, jobs_done, ctrl, job_ready);
    end
    step();
    rst_n = 1'b1;
    flags.done = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (evt_done || busy || ctrl.req_start || !q_empty) bad++;
    end
    flags.done = 1'b0;
    checks++; if (bad !== 0) begin failures++; $display("FAIL rstmid_after got=%0d bad cycles exp=0", bad); end
    checks++; if (jobs_done !== 16'd0) begin failures++; $display("FAIL rstmid_cnt got=%0d exp=0", jobs_done); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_job();
    test_spurious_done();
    test_ready_start_hold();
    test_clear();
    test_back_to_back();
    test_reset_mid_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hwpe_stream_sink_sequencer.md
HWPE_STREAM_SINK_SEQUENCER -- requirements
Module: hwpe_stream_sink_sequencer

Interface
REQ-001 SHALL have parameter NB_JOBS, default 4, meaning job queue depth (power of two, >=2).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, meaning completed-job counter width.
REQ-003 SHALL have port clk_i, input, 1, clock.
REQ-004 SHALL have port rst_ni, input, 1, reset (asynchronous, active-low).
REQ-005 SHALL have port clear_i, input, 1, synchronous flush.
REQ-006 SHALL have port job_valid_i, input, 1, job descriptor valid.
REQ-007 SHALL have port job_ready_o, output, 1, queue can accept a job.
REQ-008 SHALL have port job_i, input, ctrl_addressgen_t, job descriptor.
REQ-009 SHALL have port ctrl_o, output, ctrl_sourcesink_t, control to the stream sink.
REQ-010 SHALL have port flags_i, input, flags_sourcesink_t, flags from the stream sink.
REQ-011 SHALL have port busy_o, output, 1, high when not in SEQ_IDLE.
REQ-012 SHALL have port evt_done_o, output, 1, one-cycle pulse per completed job.
REQ-013 SHALL have port jobs_done_o, output, CNT_WIDTH, completed-job count.
REQ-014 SHALL have port queue_empty_o, output, 1, job queue empty.
REQ-015 SHALL have port queue_full_o, output, 1, job queue full.

Function
REQ-016 Queue SHALL be FIFO of NB_JOBS descriptors; push on job_valid_i & job_ready_o; job_ready_o = ~queue_full_o (no bypass when full, even if pop in same cycle).
REQ-017 Simultaneous push and pop on a non-full, non-empty queue SHALL both take effect; occupancy unchanged.
REQ-018 FSM states SHALL be SEQ_IDLE, SEQ_START, SEQ_WAIT, SEQ_DONE.
REQ-019 SEQ_IDLE -> SEQ_START when ~queue_empty_o & flags_i.ready_start; else stay.
REQ-020 SEQ_START SHALL assert ctrl_o.req_start for exactly one cycle, then -> SEQ_WAIT unconditionally.
REQ-021 SEQ_WAIT -> SEQ_DONE on flags_i.done; else stay.
REQ-022 SEQ_DONE SHALL pop the queue head, pulse evt_done_o, increment jobs_done_o, then -> SEQ_IDLE.
REQ-023 ctrl_o.addressgen_ctrl SHALL equal queue head whenever queue non-empty, else all zeros; it SHALL stay stable from SEQ_START through SEQ_DONE.
REQ-024 ctrl_o.req_start SHALL be 0 in every state except SEQ_START.
REQ-025 flags_i.done in SEQ_IDLE or SEQ_START SHALL be ignored.
REQ-026 Latency: job pushed into empty queue at cycle 0 with sink ready SHALL give req_start high at cycle 2.
REQ-027 jobs_done_o SHALL wrap modulo 2^CNT_WIDTH.
REQ-028 clear_i SHALL flush queue, force SEQ_IDLE, zero jobs_done_o and suppress evt_done_o in that cycle; a push in the same cycle is dropped.

Reset
REQ-029 On rst_ni low: state SEQ_IDLE, queue empty, jobs_done_o=0, evt_done_o=0, busy_o=0, ctrl_o all zero, job_ready_o=1, queue_empty_o=1, queue_full_o=0.
REQ-030 Reset mid-job SHALL discard all pending and in-flight jobs without evt_done_o.

Structure
REQ-031 seq_state_t (SEQ_IDLE..SEQ_DONE) SHALL be added to hwpe_stream_package; ctrl_sourcesink_t, flags_sourcesink_t, ctrl_addressgen_t reused from it.
REQ-032 Queue SHALL be a single sub-module hwpe_stream_sink_job_queue (depth NB_JOBS, payload ctrl_addressgen_t, push/pop/empty/full/clear).

Verification
REQ-033 Single job base_addr=0x1000, trans_size=16, sink ready -> req_start at cycle 2, one pulse; done at cycle 20 -> evt_done_o at cycle 21, jobs_done_o=1.
REQ-034 Push 5 jobs back-to-back, NB_JOBS=4 -> 5th held (job_ready_o=0) until first SEQ_DONE pop; all 5 executed in order, jobs_done_o=5.
REQ-035 ready_start held low 10 cycles with queue non-empty -> no req_start until ready_start rises; req_start 1 cycle after.
REQ-036 clear_i during SEQ_WAIT with 3 jobs queued -> next cycle SEQ_IDLE, queue_empty_o=1, jobs_done_o=0, no evt_done_o.
REQ-037 CNT_WIDTH=2, 5 jobs completed -> jobs_done_o sequence 1,2,3,0,1.
REQ-038 Spurious flags_i.done in SEQ_IDLE -> no state change, no evt_done_o, count unchanged.
